toy_phy_reg_release_queue: RTL and testbench

Release-side counterpart of the physical register status/allocation logic.
- Collects old-destination physical register IDs from committing instructions (up to COMMIT_NUM per cycle).
- Buffers them in a circular queue.
- Drains up to RELEASE_NUM per cycle as a registered one-cycle release bitmap, driving the regfile's per-entry release inputs.
- Sits between the ROB commit stage and the physical regfile status block, one instance per register class (INT/FP).

---
 rtl/toy_phy_reg_release_queue.sv | 155 +++++++++++++++
 tb/tb_toy_phy_reg_release_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/toy_phy_reg_release_queue.sv
// toy_phy_reg_release_queue
//   Release-side queue for one physical register class (INT or FP).
//   Collects old-destination physical IDs from committing instructions,
//   buffers them in a circular queue and drains up to RELEASE_NUM per cycle
//   as a registered one-cycle release bitmap for the regfile status block.
//
// Ports:
//   clk                clock
//   rst_n              synchronous active-low reset
//   v_commit_vld       per-lane commit valid (old mapping to be freed)
//   v_commit_old_id    per-lane old physical ID
//   commit_rdy         queue can accept a full commit group this cycle
//   v_reg_phy_release  release bitmap, one-cycle pulse per drained ID
//   queue_cnt          current occupancy
//   queue_empty        occupancy == 0
//
// Build options:
//   TOY_RELEASE_BYPASS_EN  when the queue is empty, up to RELEASE_NUM valid
//                          lanes skip the queue and release after one edge.
//   TOY_SIM                enables simulation assertions (commit while not
//                          ready, duplicate ID within one drain group).
module toy_phy_reg_release_queue #(
  parameter int unsigned MODE             = 0,
  parameter int unsigned COMMIT_NUM       = 4,
  parameter int unsigned RELEASE_NUM      = 2,
  parameter int unsigned DEPTH            = 16,
  parameter int unsigned PHY_REG_NUM      = 64,
  parameter int unsigned PHY_REG_ID_WIDTH = 6
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [COMMIT_NUM-1:0]                        v_commit_vld,
  input  logic [COMMIT_NUM-1:0][PHY_REG_ID_WIDTH-1:0]  v_commit_old_id,
  output logic                                         commit_rdy,
  output logic [PHY_REG_NUM-1:0]                       v_reg_phy_release,
  output logic [$clog2(DEPTH):0]                       queue_cnt,
  output logic                                         queue_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
  localparam logic [PW-1:0] COMMIT_P  = PW'(COMMIT_NUM);
  localparam logic [PW-1:0] RELEASE_P = PW'(RELEASE_NUM);

  // Pointers carry one extra wrap bit; slot index is the low AW bits.
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [PHY_REG_ID_WIDTH-1:0] mem [DEPTH];

  logic [COMMIT_NUM-1:0]       lane_vld;
  logic [COMMIT_NUM-1:0]       push_en;
  logic [PW-1:0]               push_off [COMMIT_NUM];
  logic [PW-1:0]               wr_addr  [COMMIT_NUM];
  logic [PW-1:0]               rd_addr  [RELEASE_NUM];
  logic [PW-1:0]               push_cnt;
  logic [PW-1:0]               drain_n;
  logic [PHY_REG_NUM-1:0]      release_next;
`ifdef TOY_RELEASE_BYPASS_EN
  int unsigned                 byp_cnt;
`endif

  assign queue_cnt   = wr_ptr - rd_ptr;
  assign queue_empty = (queue_cnt == '0);
  assign commit_rdy  = (DEPTH_P - queue_cnt) >= COMMIT_P;
  assign drain_n     = (queue_cnt < RELEASE_P) ? queue_cnt : RELEASE_P;

  // INT class never frees physical register 0; a group offered while not
  // ready is dropped whole rather than partially accepted.
  always_comb begin
    for (int unsigned i = 0; i < COMMIT_NUM; i++) begin
      lane_vld[i] = v_commit_vld[i] & commit_rdy &
                    ((MODE != 0) | (v_commit_old_id[i] != '0));
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < RELEASE_NUM; j++) begin
      rd_addr[j] = rd_ptr + PW'(j);
    end
  end

  // Lane compaction: the k-th pushed lane lands at wr_ptr + k. Only entries
  // present at start of cycle are drained into the next release bitmap.
  always_comb begin
    push_en      = '0;
    push_cnt     = '0;
    release_next = '0;
`ifdef TOY_RELEASE_BYPASS_EN
    byp_cnt      = 0;
`endif
    for (int unsigned i = 0; i < COMMIT_NUM; i++) begin
      push_off[i] = push_cnt;
      wr_addr[i]  = wr_ptr + push_cnt;
      if (lane_vld[i]) begin
`ifdef TOY_RELEASE_BYPASS_EN
        if (queue_empty && (byp_cnt < RELEASE_NUM)) begin
          release_next[v_commit_old_id[i]] = 1'b1;
          byp_cnt = byp_cnt + 1;
        end else begin
          push_en[i] = 1'b1;
          push_cnt   = push_cnt + PW'(1);
        end
`else
        push_en[i] = 1'b1;
        push_cnt   = push_cnt + PW'(1);
`endif
      end
    end
    for (int unsigned j = 0; j < RELEASE_NUM; j++) begin
      if (PW'(j) < drain_n) begin
        release_next[mem[rd_addr[j][AW-1:0]]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      v_reg_phy_release <= '0;
    end else begin
      wr_ptr            <= wr_ptr + push_cnt;
      rd_ptr            <= rd_ptr + drain_n;
      v_reg_phy_release <= release_next;
    end
  end

  // Storage needs no reset: contents outside [rd_ptr, wr_ptr) are ignored.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < COMMIT_NUM; i++) begin
      if (push_en[i]) begin
        mem[wr_addr[i][AW-1:0]] <= v_commit_old_id[i];
      end
    end
  end

`ifdef TOY_SIM
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!((|v_commit_vld) && !commit_rdy))
        else $error("commit group offered while commit_rdy is low");
      for (int unsigned j = 0; j < RELEASE_NUM; j++) begin
        for (int unsigned k = j + 1; k < RELEASE_NUM; k++) begin
          if ((PW'(k) < drain_n) &&
              (mem[rd_addr[j][AW-1:0]] == mem[rd_addr[k][AW-1:0]])) begin
            assert (1'b0) else $error("physical register released twice");
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_toy_phy_reg_release_queue.sv
module tb_toy_phy_reg_release_queue;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       vld;
  logic [3:0][5:0]  ids;

  logic             i_rdy,   f_rdy;
  logic [63:0]      i_rel,   f_rel;
  logic [4:0]       i_cnt,   f_cnt;
  logic             i_empty, f_empty;

  int errors = 0;
  int checks = 0;

  logic [5:0] mq[$];

  always #5 clk = ~clk;

  toy_phy_reg_release_queue #(.MODE(0)) u_int (
    .clk(clk), .rst_n(rst_n), .v_commit_vld(vld), .v_commit_old_id(ids),
    .commit_rdy(i_rdy), .v_reg_phy_release(i_rel),
    .queue_cnt(i_cnt), .queue_empty(i_empty)
  );

  toy_phy_reg_release_queue #(.MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .v_commit_vld(vld), .v_commit_old_id(ids),
    .commit_rdy(f_rdy), .v_reg_phy_release(f_rel),
    .queue_cnt(f_cnt), .queue_empty(f_empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference queue for the INT instance: drain from start-of-cycle contents,
  // then append the accepted group (ID 0 lanes dropped).
  function automatic logic [63:0] model_edge(input logic [3:0] v,
                                             input logic [3:0][5:0] d);
    logic [63:0] r;
    int n;
    bit rdy;
    r   = '0;
    rdy = (16 - mq.size()) >= 4;
    n   = (mq.size() < 2) ? mq.size() : 2;
    for (int k = 0; k < n; k++) r[mq.pop_front()] = 1'b1;
    if (rdy) begin
      for (int i = 0; i < 4; i++) begin
        if (v[i] && (d[i] != 6'd0)) mq.push_back(d[i]);
      end
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; vld = '0; ids = '0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (i_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", i_empty); end
    checks++; if (i_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", i_rdy); end
    checks++; if (i_rel !== 64'h0) begin errors++; $display("FAIL reset_release: got %h expected 0", i_rel); end
    checks++; if (i_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", i_cnt); end
    checks++; if (f_rel !== 64'h0) begin errors++; $display("FAIL reset_release_fp: got %h expected 0", f_rel); end
    mq.delete();
  endtask

  task automatic test_commit_group();
    vld = 4'b1011; ids[0] = 6'd5; ids[1] = 6'd9; ids[2] = 6'd33; ids[3] = 6'd12;
    tick();
    vld = '0;
    checks++; if (i_cnt !== 5'd3) begin errors++; $display("FAIL group_cnt0: got %0d expected 3", i_cnt); end
    checks++; if (i_rel !== 64'h0) begin errors++; $display("FAIL group_rel0: got %h expected 0", i_rel); end
    tick();
    checks++; if (i_cnt !== 5'd1) begin errors++; $display("FAIL group_cnt1: got %0d expected 1", i_cnt); end
    checks++; if (i_rel !== 64'h220) begin errors++; $display("FAIL group_rel1: got %h expected 220", i_rel); end
    tick();
    checks++; if (i_cnt !== 5'd0) begin errors++; $display("FAIL group_cnt2: got %0d expected 0", i_cnt); end
    checks++; if (i_rel !== 64'h1000) begin errors++; $display("FAIL group_rel2: got %h expected 1000", i_rel); end
    tick();
    checks++; if (i_rel !== 64'h0) begin errors++; $display("FAIL group_rel3: got %h expected 0", i_rel); end
    checks++; if (i_empty !== 1'b1) begin errors++; $display("FAIL group_empty: got %b expected 1", i_empty); end
  endtask

  task automatic test_mode_zero_id();
    vld = 4'b0011; ids = '0; ids[1] = 6'd7;
    tick();
    vld = '0;
    checks++; if (i_cnt !== 5'd1) begin errors++; $display("FAIL id0_int_cnt: got %0d expected 1", i_cnt); end
    checks++; if (f_cnt !== 5'd2) begin errors++; $display("FAIL id0_fp_cnt: got %0d expected 2", f_cnt); end
    checks++; if (i_rel !== 64'h0) begin errors++; $display("FAIL id0_rel0: got %h expected 0", i_rel); end
    tick();
    checks++; if (i_rel !== 64'h80) begin errors++; $display("FAIL id0_int_rel: got %h expected 80", i_rel); end
    checks++; if (f_rel !== 64'h81) begin errors++; $display("FAIL id0_fp_rel: got %h expected 81", f_rel); end
    checks++; if (i_cnt !== 5'd0) begin errors++; $display("FAIL id0_int_cnt1: got %0d expected 0", i_cnt); end
    tick();
    checks++; if (i_rel !== 64'h0) begin errors++; $display("FAIL id0_int_rel1: got %h expected 0", i_rel); end
    checks++; if (f_rel !== 64'h0) begin errors++; $display("FAIL id0_fp_rel1: got %h expected 0", f_rel); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_rel;
    logic [63:0] acc;
    int          nrel;
    bit          exp_rdy;
    acc = '0; nrel = 0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 4; i++) ids[i] = 6'(1 + 4 * c + i);
      vld = 4'hF;
      exp_rdy = (16 - mq.size()) >= 4;
      checks++; if (i_rdy !== exp_rdy) begin errors++; $display("FAIL b2b_rdy[%0d]: got %b expected %b", c, i_rdy, exp_rdy); end
      exp_rel = model_edge(vld, ids);
      tick();
      vld = '0;
      checks++; if (i_rel !== exp_rel) begin errors++; $display("FAIL b2b_rel[%0d]: got %h expected %h", c, i_rel, exp_rel); end
      checks++; if (i_cnt !== 5'(mq.size())) begin errors++; $display("FAIL b2b_cnt[%0d]: got %0d expected %0d", c, i_cnt, mq.size()); end
      acc |= i_rel; nrel += $countones(i_rel);
    end
    checks++; if (i_cnt !== 5'd14) begin errors++; $display("FAIL b2b_peak_cnt: got %0d expected 14", i_cnt); end
    checks++; if (i_rdy !== 1'b0) begin errors++; $display("FAIL b2b_rdy_low: got %b expected 0", i_rdy); end
    for (int c = 0; c < 10; c++) begin
      exp_rel = model_edge(4'h0, ids);
      tick();
      checks++; if (i_rel !== exp_rel) begin errors++; $display("FAIL b2b_drain_rel[%0d]: got %h expected %h", c, i_rel, exp_rel); end
      acc |= i_rel; nrel += $countones(i_rel);
    end
    checks++; if (acc !== 64'h1FF_FFFE) begin errors++; $display("FAIL b2b_all_ids: got %h expected 1fffffe", acc); end
    checks++; if (nrel !== 24) begin errors++; $display("FAIL b2b_release_count: got %0d expected 24", nrel); end
    checks++; if (i_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", i_empty); end
  endtask

  task automatic test_wrap();
    logic [3:0]  wvld [5] = '{4'hF, 4'hF, 4'hF, 4'h3, 4'hF};
    logic [63:0] exp_rel;
    logic [63:0] acc;
    bit          exp_rdy;
    int          next_id;
    rst_n = 1'b0; vld = '0;
    tick();
    rst_n = 1'b1;
    mq.delete();
    acc = '0; next_id = 30;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 4; i++) begin
        ids[i] = 6'(next_id);
        if (wvld[c][i]) next_id++;
      end
      vld = wvld[c];
      exp_rdy = (16 - mq.size()) >= 4;
      checks++; if (i_rdy !== exp_rdy) begin errors++; $display("FAIL wrap_rdy[%0d]: got %b expected %b", c, i_rdy, exp_rdy); end
      exp_rel = model_edge(vld, ids);
      tick();
      vld = '0;
      checks++; if (i_rel !== exp_rel) begin errors++; $display("FAIL wrap_rel[%0d]: got %h expected %h", c, i_rel, exp_rel); end
      checks++; if (i_cnt !== 5'(mq.size())) begin errors++; $display("FAIL wrap_cnt[%0d]: got %0d expected %0d", c, i_cnt, mq.size()); end
      if (c == 3) begin
        checks++; if (i_cnt !== 5'd8) begin errors++; $display("FAIL wrap_cnt_at14: got %0d expected 8", i_cnt); end
      end
      acc |= i_rel;
    end
    checks++; if (i_cnt !== 5'd10) begin errors++; $display("FAIL wrap_cnt_after: got %0d expected 10", i_cnt); end
    for (int c = 0; c < 8; c++) begin
      exp_rel = model_edge(4'h0, ids);
      tick();
      checks++; if (i_rel !== exp_rel) begin errors++; $display("FAIL wrap_drain_rel[%0d]: got %h expected %h", c, i_rel, exp_rel); end
      acc |= i_rel;
    end
    checks++; if (acc !== 64'h0000_FFFF_C000_0000) begin errors++; $display("FAIL wrap_all_ids: got %h expected 0000ffffc0000000", acc); end
    checks++; if (i_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", i_empty); end
  endtask

  task automatic test_reset_midop();
    vld = 4'hF; ids[0] = 6'd50; ids[1] = 6'd51; ids[2] = 6'd52; ids[3] = 6'd53;
    tick();
    ids[0] = 6'd54; ids[1] = 6'd55; ids[2] = 6'd56; ids[3] = 6'd57;
    tick();
    vld = '0;
    checks++; if (i_cnt !== 5'd6) begin errors++; $display("FAIL mid_cnt_before: got %0d expected 6", i_cnt); end
    rst_n = 1'b0;
    tick();
    checks++; if (i_cnt !== 5'd0) begin errors++; $display("FAIL mid_cnt_reset: got %0d expected 0", i_cnt); end
    checks++; if (i_rel !== 64'h0) begin errors++; $display("FAIL mid_rel_reset: got %h expected 0", i_rel); end
    checks++; if (i_empty !== 1'b1) begin errors++; $display("FAIL mid_empty_reset: got %b expected 1", i_empty); end
    rst_n = 1'b1;
    mq.delete();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (i_rel !== 64'h0) begin errors++; $display("FAIL mid_stale_rel[%0d]: got %h expected 0", c, i_rel); end
      checks++; if (i_cnt !== 5'd0) begin errors++; $display("FAIL mid_stale_cnt[%0d]: got %0d expected 0", c, i_cnt); end
    end
    vld = 4'b0001; ids = '0; ids[0] = 6'd3;
    tick();
    vld = '0;
    checks++; if (i_cnt !== 5'd1) begin errors++; $display("FAIL mid_push_cnt: got %0d expected 1", i_cnt); end
    checks++; if (i_rel !== 64'h0) begin errors++; $display("FAIL mid_push_rel0: got %h expected 0", i_rel); end
    tick();
    checks++; if (i_rel !== 64'h8) begin errors++; $display("FAIL mid_push_rel1: got %h expected 8", i_rel); end
    tick();
    checks++; if (i_rel !== 64'h0) begin errors++; $display("FAIL mid_push_rel2: got %h expected 0", i_rel); end
  endtask

  initial begin
    test_reset();
    test_commit_group();
    test_mode_zero_id();
    test_back_to_back();
    test_wrap();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
